// File: rtl/siggen_pkg.sv
// siggen_pkg: shared encodings and LFSR step for the test pattern source (rev 1.0).
`default_nettype none

package siggen_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_CONST  = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] CH_SEED_STEP = 32'h9E37_79B9;

  // Galois step: shift right, fold the polynomial in when a 1 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/siggen_lfsr32.sv
// siggen_lfsr32: 32-bit Galois LFSR with seed load and single-step advance (rev 1.0).
`default_nettype none

module siggen_lfsr32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);
  import siggen_pkg::*;

  // An all-zero state would lock up, so a zero seed becomes 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 32'd1;
    end else if (load) begin
      state <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

`default_nettype wire

// File: rtl/test_pattern_source.sv
// test_pattern_source: multi-channel random/ramp/constant/square sample generator (rev 1.0).
// Optional build macro SIGGEN_OVERRUN_CNT_EN adds the saturating overrun counter.
`default_nettype none

module test_pattern_source #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_DIV = 250,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [31:0]              seed,
  input  logic [CNT_W-1:0]         num_samples,
  output logic [NUM_CH*DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         sample_idx,
  output logic [15:0]              overrun_cnt
);
  import siggen_pkg::*;

  localparam int                DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DATA_W-1:0] SQ_POS   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SQ_NEG   = {1'b1, {(DATA_W-1){1'b0}}};

  state_e                     state_q;
  mode_e                      mode_q;
  logic [DIV_W-1:0]           div_q;
  logic [DATA_W-1:0]          const_val_q;
  logic [CNT_W-1:0]           nsamp_q;
  logic [CNT_W-1:0]           next_n_q;
  logic [CNT_W-1:0]           sample_idx_q;
  logic [NUM_CH*DATA_W-1:0]   sample_out_q;
  logic [NUM_CH*DATA_W-1:0]   sample_d;
  logic                       sample_valid_q;
  logic                       busy_q;
  logic                       done_q;

  logic w_start, w_in_run, w_tick, w_hs, w_last_hs, w_end, w_load;

  assign w_start   = (state_q == ST_IDLE) && start;
  assign w_in_run  = (state_q == ST_RUN);
  assign w_tick    = w_in_run && (div_q == DIV_LAST);
  assign w_hs      = sample_valid_q && sample_ready;
  assign w_last_hs = w_hs && (nsamp_q != '0) && (sample_idx_q == nsamp_q - CNT_W'(1));
  assign w_end     = w_in_run && (stop || w_last_hs);
  // A tick only loads when the output slot is free or being emptied this cycle.
  assign w_load    = w_tick && (!sample_valid_q || w_hs) && !w_end;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [31:0]       w_ch_seed;
    logic [31:0]       w_lfsr;
    logic [DATA_W-1:0] w_ch_sample;

    assign w_ch_seed = seed ^ (32'(k) * CH_SEED_STEP);

    siggen_lfsr32 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (w_start),
      .seed    (w_ch_seed),
      .advance (w_load),
      .state   (w_lfsr)
    );

    always_comb begin
      w_ch_sample = '0;
      case (mode_q)
        MODE_RANDOM: w_ch_sample = DATA_W'(lfsr_next(w_lfsr));
        MODE_RAMP:   w_ch_sample = DATA_W'(next_n_q) + DATA_W'(k);
        MODE_CONST:  w_ch_sample = const_val_q;
        MODE_SQUARE: w_ch_sample = next_n_q[0] ? SQ_NEG : SQ_POS;
        default:     w_ch_sample = '0;
      endcase
    end

    assign sample_d[k*DATA_W +: DATA_W] = w_ch_sample;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_RANDOM;
      div_q          <= '0;
      const_val_q    <= '0;
      nsamp_q        <= '0;
      next_n_q       <= '0;
      sample_idx_q   <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q      <= ST_RUN;
            busy_q       <= 1'b1;
            div_q        <= '0;
            mode_q       <= mode_e'(mode);
            const_val_q  <= seed[DATA_W-1:0];
            nsamp_q      <= num_samples;
            next_n_q     <= '0;
            sample_idx_q <= '0;
          end
        end
        ST_RUN: begin
          div_q <= w_tick ? '0 : div_q + DIV_W'(1);
          if (w_end) begin
            state_q        <= ST_DONE;
            done_q         <= 1'b1;
            sample_valid_q <= 1'b0;
          end else if (w_load) begin
            sample_out_q   <= sample_d;
            sample_valid_q <= 1'b1;
            sample_idx_q   <= next_n_q;
            next_n_q       <= next_n_q + CNT_W'(1);
          end else if (w_hs) begin
            sample_valid_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          div_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_idx   = sample_idx_q;

`ifdef SIGGEN_OVERRUN_CNT_EN
  logic [15:0] overrun_q;
  logic        w_overrun;

  assign w_overrun = w_tick && sample_valid_q && !sample_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= '0;
    end else if (w_start) begin
      overrun_q <= '0;
    end else if (w_overrun && (overrun_q != 16'hFFFF)) begin
      overrun_q <= overrun_q + 16'd1;
    end
  end

  assign overrun_cnt = overrun_q;
`else
  assign overrun_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_test_pattern_source.sv
// tb_test_pattern_source: randomized self-checking bench against a behavioural sample model.
`default_nettype none

module tb_test_pattern_source;
  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int DIV = 4;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [31:0]       seed = 32'd0;
  logic [CW-1:0]     num_samples = '0;
  logic [NCH*DW-1:0] sample_out;
  logic              sample_valid;
  logic              sample_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [CW-1:0]     sample_idx;
  logic [15:0]       overrun_cnt;

  test_pattern_source #(.DATA_W(DW), .NUM_CH(NCH), .SAMPLE_DIV(DIV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .num_samples(num_samples), .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .done(done), .sample_idx(sample_idx),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  bit rdy_rand = 1'b0;
  bit rdy_fixed = 1'b1;
  logic [NCH*DW-1:0] cap_data[$];
  int cap_idx[$];
  int cap_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    sample_ready = rdy_rand ? ($urandom_range(0, 99) < 70) : rdy_fixed;
  end

  // Accepted samples: valid && ready seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (sample_valid && sample_ready) begin
      cap_data.push_back(sample_out);
      cap_idx.push_back(int'(sample_idx));
      cap_cyc.push_back(cyc);
    end
  end

  // Expected channel k value of sample n, straight from the pattern definitions.
  function automatic logic [DW-1:0] model(int md, logic [31:0] sd, int k, int n);
    logic [31:0] s;
    case (md)
      0: begin
        s = sd ^ (32'(k) * 32'h9E3779B9);
        if (s == 32'd0) s = 32'd1;
        for (int i = 0; i <= n; i++) begin
          if (s & 32'd1) s = (s >> 1) ^ 32'h80200003;
          else           s = s >> 1;
        end
        return s[DW-1:0];
      end
      1: return DW'(n + k);
      2: return sd[DW-1:0];
      default: return (n % 2 == 0) ? DW'((1 << (DW-1)) - 1) : DW'(1 << (DW-1));
    endcase
  endfunction

  task automatic do_start(input int md, input logic [31:0] sd, input int ns, output int s_cyc);
    @(posedge clk); #2;
    start = 1'b1; mode = 2'(md); seed = sd; num_samples = CW'(ns);
    @(posedge clk); #2;
    s_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic clear_caps();
    cap_data.delete(); cap_idx.delete(); cap_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sample_out !== '0) begin errors++; $display("FAIL reset_data got %h want 0", sample_out); end
    checks++; if (sample_idx !== '0) begin errors++; $display("FAIL reset_idx got %0d want 0", sample_idx); end
    checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_overrun got %0d want 0", overrun_cnt); end
    @(posedge clk); #2; rst = 1'b0;
  endtask

  task automatic test_lfsr_seed1();
    int sc, d0; bit ok; logic [NCH*DW-1:0] t;
    rdy_rand = 1'b0; rdy_fixed = 1'b1; clear_caps(); d0 = done_seen;
    do_start(0, 32'd1, 2, sc);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lfsr_timeout busy=%b want 0", busy); end
    checks++; if (cap_data.size() != 2) begin errors++; $display("FAIL lfsr_count got %0d want 2", cap_data.size()); end
    else begin
      t = cap_data[0];
      checks++; if (t[DW-1:0] !== 16'h0003) begin errors++; $display("FAIL lfsr_s0 got %h want 0003", t[DW-1:0]); end
      checks++; if (t[DW +: DW] !== model(0, 32'd1, 1, 0)) begin errors++; $display("FAIL lfsr_s0_ch1 got %h want %h", t[DW +: DW], model(0, 32'd1, 1, 0)); end
      t = cap_data[1];
      checks++; if (t[DW-1:0] !== 16'h0002) begin errors++; $display("FAIL lfsr_s1 got %h want 0002", t[DW-1:0]); end
      checks++; if (cap_cyc[0] - sc != DIV) begin errors++; $display("FAIL lfsr_latency got %0d want %0d", cap_cyc[0] - sc, DIV); end
    end
    checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL lfsr_done_pulses got %0d want 1", done_seen - d0); end
  endtask

  task automatic test_ramp();
    int sc, d0; bit ok; logic [NCH*DW-1:0] t;
    rdy_rand = 1'b0; rdy_fixed = 1'b1; clear_caps(); d0 = done_seen;
    do_start(1, 32'hDEAD_BEEF, 3, sc);
    wait_idle(100, ok);
    checks++; if (!ok || cap_data.size() != 3) begin errors++; $display("FAIL ramp_count got %0d want 3", cap_data.size()); end
    else begin
      for (int n = 0; n < 3; n++) begin
        t = cap_data[n];
        checks++; if (t[DW-1:0] !== DW'(n) || t[DW +: DW] !== DW'(n + 1)) begin
          errors++; $display("FAIL ramp_s%0d got %h want %h_%h", n, t, DW'(n + 1), DW'(n));
        end
        checks++; if (cap_idx[n] != n) begin errors++; $display("FAIL ramp_idx got %0d want %0d", cap_idx[n], n); end
      end
    end
    checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL ramp_done_pulses got %0d want 1", done_seen - d0); end
  endtask

  task automatic test_random_runs();
    int sc, d0, md, ns; logic [31:0] sd; bit ok; logic [NCH*DW-1:0] t;
    for (int r = 0; r < 8; r++) begin
      md = $urandom_range(0, 3); sd = $urandom; ns = $urandom_range(1, 6);
      if (r == 0) sd = 32'd0;
      rdy_rand = 1'b1; clear_caps(); d0 = done_seen;
      do_start(md, sd, ns, sc);
      wait_idle(2000, ok);
      checks++; if (!ok || cap_data.size() != ns) begin errors++; $display("FAIL rand_run%0d_count got %0d want %0d", r, cap_data.size(), ns); end
      else begin
        for (int n = 0; n < ns; n++) begin
          t = cap_data[n];
          for (int k = 0; k < NCH; k++) begin
            checks++; if (t[k*DW +: DW] !== model(md, sd, k, n)) begin
              errors++; $display("FAIL rand_run%0d_m%0d_s%0d_ch%0d got %h want %h", r, md, n, k, t[k*DW +: DW], model(md, sd, k, n));
            end
          end
          checks++; if (cap_idx[n] != n) begin errors++; $display("FAIL rand_idx got %0d want %0d", cap_idx[n], n); end
        end
      end
      checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL rand_done_pulses got %0d want 1", done_seen - d0); end
    end
    rdy_rand = 1'b0;
  endtask

  task automatic test_overrun();
    int sc; bit ok, seen; logic [NCH*DW-1:0] held;
    logic [15:0] want_ovr;
`ifdef SIGGEN_OVERRUN_CNT_EN
    want_ovr = 16'd3;
`else
    want_ovr = 16'd0;
`endif
    rdy_rand = 1'b0; rdy_fixed = 1'b0;
    do_start(1, 32'd0, 0, sc);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = sample_valid; end
    checks++; if (!seen) begin errors++; $display("FAIL ovr_first_valid got 0 want 1"); end
    held = sample_out;
    repeat (3 * DIV) @(negedge clk);
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", sample_valid); end
    checks++; if (sample_out !== held || held !== {DW'(1), DW'(0)}) begin errors++; $display("FAIL ovr_hold got %h want %h", sample_out, {DW'(1), DW'(0)}); end
    checks++; if (sample_idx !== '0) begin errors++; $display("FAIL ovr_idx got %0d want 0", sample_idx); end
    checks++; if (overrun_cnt !== want_ovr) begin errors++; $display("FAIL ovr_count got %0d want %0d", overrun_cnt, want_ovr); end
    @(posedge clk); #2; stop = 1'b1;
    @(posedge clk); #2; stop = 1'b0;
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_stop_idle busy=%b want 0", busy); end
    rdy_fixed = 1'b1;
  endtask

  task automatic test_stop();
    int sc, d0; bit seen; logic [NCH*DW-1:0] t;
    rdy_rand = 1'b0; rdy_fixed = 1'b1; clear_caps(); d0 = done_seen;
    do_start(1, 32'd0, 0, sc);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin @(negedge clk); seen = sample_valid && (sample_idx == CW'(1)); end
    rdy_fixed = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL stop_sample1 got 0 want 1"); end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin @(negedge clk); seen = sample_valid; end
    checks++; if (!seen || sample_idx !== CW'(2)) begin errors++; $display("FAIL stop_held_idx got %0d want 2", sample_idx); end
    @(posedge clk); #2; stop = 1'b1;
    @(posedge clk); #2; stop = 1'b0;
    @(negedge clk);
    checks++; if (sample_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL stop_next valid=%b done=%b busy=%b want 0 1 1", sample_valid, done, busy);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_idle done=%b busy=%b want 0 0", done, busy); end
    checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL stop_done_pulses got %0d want 1", done_seen - d0); end
    checks++; if (cap_data.size() != 2) begin errors++; $display("FAIL stop_accepted got %0d want 2", cap_data.size()); end
    else begin
      t = cap_data[1];
      checks++; if (t !== {DW'(2), DW'(1)}) begin errors++; $display("FAIL stop_s1 got %h want %h", t, {DW'(2), DW'(1)}); end
    end
    rdy_fixed = 1'b1;
  endtask

  task automatic test_reset_midrun();
    int sc, d0; bit ok, seen; logic [NCH*DW-1:0] t;
    rdy_rand = 1'b0; rdy_fixed = 1'b1; d0 = done_seen;
    do_start(2, 32'h1234_ABCD, 0, sc);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = sample_valid; end
    @(posedge clk); #3; rst = 1'b1; #1;
    checks++; if (sample_out !== '0 || sample_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async data=%h valid=%b busy=%b want 0 0 0", sample_out, sample_valid, busy);
    end
    @(posedge clk); #2; rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_seen != d0) begin errors++; $display("FAIL rstmid_done_pulses got %0d want 0", done_seen - d0); end
    clear_caps(); d0 = done_seen;
    do_start(3, 32'd0, 3, sc);
    wait_idle(100, ok);
    checks++; if (!ok || cap_data.size() != 3) begin errors++; $display("FAIL square_count got %0d want 3", cap_data.size()); end
    else begin
      t = cap_data[0];
      checks++; if (t !== 32'h7FFF_7FFF) begin errors++; $display("FAIL square_s0 got %h want 7fff7fff", t); end
      t = cap_data[1];
      checks++; if (t !== 32'h8000_8000) begin errors++; $display("FAIL square_s1 got %h want 80008000", t); end
      t = cap_data[2];
      checks++; if (t !== 32'h7FFF_7FFF) begin errors++; $display("FAIL square_s2 got %h want 7fff7fff", t); end
    end
    checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL square_done_pulses got %0d want 1", done_seen - d0); end
  endtask

  task automatic test_start_while_busy();
    int sc, d0; bit ok; logic [NCH*DW-1:0] t;
    rdy_rand = 1'b0; rdy_fixed = 1'b1; clear_caps(); d0 = done_seen;
    do_start(1, 32'd0, 4, sc);
    for (int j = 0; j < 3; j++) begin
      repeat (3) @(posedge clk); #2;
      start = 1'b1; mode = 2'($urandom_range(0, 3)); seed = $urandom; num_samples = CW'(1);
      @(posedge clk); #2; start = 1'b0;
    end
    wait_idle(100, ok);
    checks++; if (!ok || cap_data.size() != 4) begin errors++; $display("FAIL busy_start_count got %0d want 4", cap_data.size()); end
    else begin
      for (int n = 0; n < 4; n++) begin
        t = cap_data[n];
        checks++; if (t !== {DW'(n + 1), DW'(n)}) begin errors++; $display("FAIL busy_start_s%0d got %h want %h", n, t, {DW'(n + 1), DW'(n)}); end
        checks++; if (cap_cyc[n] - sc != DIV * (n + 1)) begin
          errors++; $display("FAIL busy_start_time%0d got %0d want %0d", n, cap_cyc[n] - sc, DIV * (n + 1));
        end
      end
    end
    checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL busy_start_done_pulses got %0d want 1", done_seen - d0); end
  endtask

  initial begin
    test_reset();
    test_lfsr_seed1();
    test_ramp();
    test_random_runs();
    test_overrun();
    test_stop();
    test_reset_midrun();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/test_pattern_source.md
TEST_PATTERN_SOURCE -- requirements
Module: test_pattern_source

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: sample width per channel, range 8..32.
REQ-002 The block SHALL have parameter NUM_CH, default 2: number of channels, range 1..8.
REQ-003 The block SHALL have parameter SAMPLE_DIV, default 250: clock cycles per sample period, minimum 2.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the sample counter.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: begin a run; sampled only in IDLE.
REQ-008 The block SHALL have port stop, input, 1 bit: abort the current run.
REQ-009 The block SHALL have port mode, input, 2 bits: 0 = random, 1 = ramp, 2 = constant, 3 = square; latched at start.
REQ-010 The block SHALL have port seed, input, 32 bits: LFSR seed or constant value; latched at start.
REQ-011 The block SHALL have port num_samples, input, CNT_W bits: samples per run, 0 = free-running; latched at start.
REQ-012 The block SHALL have port sample_out, output, NUM_CH*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-013 The block SHALL have port sample_valid, output, 1 bit; and port sample_ready, input, 1 bit: handshake for sample_out.
REQ-014 The block SHALL have ports busy (output, 1 bit), done (output, 1 bit), sample_idx (output, CNT_W bits), and overrun_cnt (output, 16 bits).

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; start in IDLE -> RUN; start outside IDLE is ignored.
REQ-016 On start, the divider SHALL clear to 0 and then count 0..SAMPLE_DIV-1; a tick occurs when the divider equals SAMPLE_DIV-1, and the divider then wraps to 0.
REQ-017 On a tick with sample_valid low, sample_out SHALL load a new sample and sample_valid SHALL rise; the first sample_valid is high after the SAMPLE_DIV-th rising edge following the edge that sampled start.
REQ-018 sample_valid and sample_out SHALL hold stable until a cycle with sample_valid && sample_ready; sample_valid then drops unless a tick loads a new sample in the same cycle.
REQ-019 A tick while sample_valid is high and sample_ready is low SHALL be an overrun: the held sample is kept, the tick is dropped, and no generator advance occurs.
REQ-020 sample_idx SHALL equal the index (0-based) of the sample currently or last presented, and increments on each load.
REQ-021 Random mode: each channel SHALL use its own 32-bit Galois LFSR (shift right, XOR 0x80200003 when the shifted-out LSB is 1), seeded with seed ^ (k * 0x9E3779B9), with a zero seed replaced by 1; the LFSR advances once per load, and the sample is the low DATA_W bits after the advance.
REQ-022 Ramp mode: channel k SHALL output (n + k) mod 2^DATA_W for sample n.
REQ-023 Constant mode: all channels SHALL output seed[DATA_W-1:0].
REQ-024 Square mode: all channels SHALL output the most positive two's-complement value for even n and the most negative value for odd n.
REQ-025 When num_samples != 0 and the handshake of sample num_samples-1 completes, the FSM SHALL go RUN -> DONE; done pulses high for exactly one cycle in DONE, then the FSM goes DONE -> IDLE.
REQ-026 stop in RUN SHALL drop sample_valid on the next edge, discard any pending sample, and go to DONE; if stop and a handshake occur in the same cycle, the handshake counts.
REQ-027 busy SHALL be high in RUN and DONE.

Reset
REQ-028 rst SHALL force, asynchronously: state IDLE, divider 0, sample_out 0, sample_valid 0, done 0, busy 0, sample_idx 0, overrun_cnt 0, all LFSRs to 1.
REQ-029 rst asserted mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-030 With SIGGEN_OVERRUN_CNT_EN defined, overrun_cnt SHALL increment (saturating at 0xFFFF) on each overrun and clear on start; without it, overrun_cnt SHALL be constant 0 and no counter logic is present.

Structure
REQ-031 Package siggen_pkg SHALL hold the mode encoding, the FSM state encoding, LFSR_POLY = 0x80200003 and CH_SEED_STEP = 0x9E3779B9.
REQ-032 The LFSR SHALL be sub-module siggen_lfsr32 (ports clk, rst, load, seed, advance, state), instantiated NUM_CH times.

Verification
REQ-033 NUM_CH=1, SAMPLE_DIV=4, mode 0, seed 1, num_samples 2, ready held 1 -> samples 0x0003 then 0x0002, then a one-cycle done pulse.
REQ-034 NUM_CH=2, mode 1, num_samples 3 -> channel 0 outputs 0,1,2; channel 1 outputs 1,2,3; sample_idx 0,1,2.
REQ-035 Ready held 0 for 3 ticks -> first sample held unchanged and, with the macro defined, overrun_cnt = 3; without the macro, overrun_cnt = 0.
REQ-036 stop asserted after sample 1 with num_samples 0 -> valid drops next cycle, done pulses once, FSM in IDLE.
REQ-037 rst pulsed mid-run, then restart with mode 3 and DATA_W=16 -> samples 0x7FFF, 0x8000, 0x7FFF, with no done pulse during the reset.
REQ-038 start pulsed while busy -> ignored; sample sequence and timing unchanged.
